split_mfft_to_two_sfft: RTL and testbench
=========================================

SPLIT_MFFT_TO_TWO_SFFT -- requirements
Module: split_mfft_to_two_sfft

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 3, log2(NFFT); legal range 2..12.
REQ-002 SHALL have parameter DATA_FFT_SIZE, default 16, two's-complement width of I and Q.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_data_i, in_data_q  input  DATA_FFT_SIZE  serial time-domain sample, natural order n=0..NFFT-1.
REQ-006 in_valid  input  1  sample present.
REQ-007 in_start  input  1  qualified by in_valid; marks sample n=0.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 out_chet_i, out_chet_q  output  DATA_FFT_SIZE  even sample x[2k] to the even sub-FFT.
REQ-010 out_Nchet_i, out_Nchet_q  output  DATA_FFT_SIZE  odd sample x[2k+1] to the odd sub-FFT.
REQ-011 out_valid  output  1  pair present on both output streams.
REQ-012 out_ready  input  1  AND of both sub-FFT ready signals; pair consumed when out_valid & out_ready.
REQ-013 out_index  output  SIZE_BUFFER-1  pair index k.
REQ-014 out_first, out_last  output  1  k==0 and k==NFFT/2-1 respectively.
REQ-015 err_sync  output  1  sticky misalignment flag.

Function
REQ-016 Input FSM SHALL have states WAIT_EVEN and WAIT_ODD; sample accepted on in_valid & in_ready.
REQ-017 In WAIT_EVEN, an accepted sample SHALL be latched into the even holding register, and the FSM SHALL go to WAIT_ODD.
REQ-018 In WAIT_ODD, an accepted sample SHALL push {even, odd, k} into a 2-entry pair FIFO, and the FSM SHALL return to WAIT_EVEN.
REQ-019 in_ready SHALL be 1 in WAIT_EVEN, and !fifo_full in WAIT_ODD; it SHALL NOT depend combinationally on out_ready.
REQ-020 Push SHALL be blocked when the FIFO is full, even if a pop occurs in the same cycle; simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-021 Latency: out_valid SHALL assert the cycle after the odd sample is accepted, if the FIFO was empty.
REQ-022 Throughput: with out_ready=1, SHALL sustain 1 sample/cycle indefinitely.
REQ-023 out_* data, out_index, out_first and out_last SHALL be held stable while out_valid & !out_ready.
REQ-024 The sample counter (SIZE_BUFFER bits) SHALL increment per accepted sample and wrap from NFFT-1 to 0; k equals counter[SIZE_BUFFER-1:1] of the odd sample.
REQ-025 Accepted in_start with counter==0 and FSM in WAIT_EVEN SHALL be normal operation.
REQ-026 Accepted in_start with counter!=0 SHALL discard any held even sample, treat the current sample as n=0 (even), set the counter to 1 and the FSM to WAIT_ODD, and set err_sync. Pairs already in the FIFO SHALL be kept.
REQ-027 in_start deasserted SHALL NOT be required; framing SHALL free-run by counter wrap.
REQ-028 Data SHALL pass unmodified, with no width change, scaling or sign extension.

Reset
REQ-029 Reset SHALL set: FSM to WAIT_EVEN, counter 0, FIFO empty, out_valid 0, in_ready 1, err_sync 0, out_index 0, out_first 0, out_last 0, and out data 0.
REQ-030 Reset mid-frame SHALL drop the held even sample and FIFO contents, with no pair emitted afterwards from pre-reset data.
REQ-031 err_sync SHALL clear only by reset.

Structure
REQ-032 NFFT=1<<SIZE_BUFFER and the FSM state encodings SHALL be localparams in the team's shared FFT constants header, alongside the mFFT-side definitions.
REQ-033 The 2-entry pair FIFO SHALL be one sub-module, fifo_pair2, parameterized by entry width (2*2*DATA_FFT_SIZE+SIZE_BUFFER-1), with push/pop/full/empty.
REQ-034 The top level SHALL contain the FSM, even holding register, counter and error logic only.

Verification (SIZE_BUFFER=3, DATA_FFT_SIZE=16)
REQ-035 Streaming: in_start on n=0, in_data_i=n, in_data_q=-n for n=0..7 back-to-back, out_ready=1 -> 4 pairs on consecutive cycles: (0,1), (2,3), (4,5), (6,7); out_index 0..3; out_first only on k=0; out_last only on k=3; first out_valid one cycle after n=1 is accepted.
REQ-036 Backpressure: same stream with out_ready=0 -> in_ready drops after 5 samples are accepted (2 pairs plus 1 held even); raising out_ready resumes flow with no loss or duplication and stable outputs while stalled.
REQ-037 Resync: in_start on n=0, then 3 samples, then in_start with value 0x0100 -> err_sync=1, the pair (x0,x1) is output, the partial sample x2 is discarded, and the next pair is (0x0100, following sample) with out_index=0.
REQ-038 Reset mid-frame: after 3 samples are accepted, assert reset 1 cycle -> out_valid=0, in_ready=1; next frame starting with in_start outputs index 0 with post-reset data only.
REQ-039 Random valid/ready: 1000 frames with random in_valid/out_ready gaps -> scoreboard matches all pairs, no out_index skips, and err_sync stays 0.

Source files
------------

// File: rtl/split_mfft_to_two_sfft_pkg.sv
// Shared FFT constants: mFFT-side sizing and
// the even/odd splitter FSM encodings.
package split_mfft_to_two_sfft_pkg;

    localparam int MFFT_SIZE_BUFFER = 3;
    localparam int MFFT_DATA_SIZE   = 16;
    localparam int MFFT_NFFT        = 1 << MFFT_SIZE_BUFFER;

    localparam logic [0:0] WAIT_EVEN = 1'b0;
    localparam logic [0:0] WAIT_ODD  = 1'b1;

    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

endpackage

// File: rtl/fifo_pair2.sv
// Two-entry FIFO holding one even/odd pair
// plus its index per entry.
module fifo_pair2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // a pop never frees space for a push in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push}
                           - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/split_mfft_to_two_sfft.sv
// Splits a serial mFFT sample stream into
// even/odd pairs for two half-size sub-FFTs.
module split_mfft_to_two_sfft
    import split_mfft_to_two_sfft_pkg::*;
#(
    parameter int SIZE_BUFFER   = 3,
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_FFT_SIZE-1:0] in_data_i,
    input  logic [DATA_FFT_SIZE-1:0] in_data_q,
    input  logic                     in_valid,
    input  logic                     in_start,
    output logic                     in_ready,
    output logic [DATA_FFT_SIZE-1:0] out_chet_i,
    output logic [DATA_FFT_SIZE-1:0] out_chet_q,
    output logic [DATA_FFT_SIZE-1:0] out_Nchet_i,
    output logic [DATA_FFT_SIZE-1:0] out_Nchet_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_BUFFER-2:0]   out_index,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     err_sync
);

    localparam int NFFT = nfft(SIZE_BUFFER);
    localparam int KW   = SIZE_BUFFER - 1;
    localparam int EW   = 4 * DATA_FFT_SIZE + KW;
    localparam logic [KW-1:0] K_LAST = KW'(NFFT / 2 - 1);

    logic [0:0]               state;
    logic [SIZE_BUFFER-1:0]   counter;
    logic [DATA_FFT_SIZE-1:0] even_i;
    logic [DATA_FFT_SIZE-1:0] even_q;
    logic                     accept;
    logic                     resync;
    logic                     push;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [EW-1:0]            fifo_din;
    logic [EW-1:0]            fifo_dout;

    assign in_ready = (state == WAIT_EVEN) || !fifo_full;
    assign accept   = in_valid && in_ready;
    assign resync   = accept && in_start
                   && (counter != '0);
    assign push     = accept && !resync
                   && (state == WAIT_ODD);
    assign fifo_din = {even_i, even_q,
                       in_data_i, in_data_q,
                       counter[SIZE_BUFFER-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_EVEN;
            counter  <= '0;
            even_i   <= '0;
            even_q   <= '0;
            err_sync <= 1'b0;
        end else if (resync) begin
            // restart the frame on this sample
            state    <= WAIT_ODD;
            counter  <= SIZE_BUFFER'(1);
            even_i   <= in_data_i;
            even_q   <= in_data_q;
            err_sync <= 1'b1;
        end else if (accept) begin
            counter <= counter + 1'b1;
            if (state == WAIT_EVEN) begin
                even_i <= in_data_i;
                even_q <= in_data_q;
                state  <= WAIT_ODD;
            end else begin
                state  <= WAIT_EVEN;
            end
        end
    end

    fifo_pair2 #(
        .WIDTH(EW)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (out_valid && out_ready),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign {out_chet_i, out_chet_q,
            out_Nchet_i, out_Nchet_q,
            out_index} = fifo_dout;
    assign out_first = out_valid
                    && (out_index == '0);
    assign out_last  = out_valid
                    && (out_index == K_LAST);

endmodule

// File: tb/tb_split_mfft_to_two_sfft.sv
// Randomized and directed bench for the
// even/odd mFFT splitter.
module tb_split_mfft_to_two_sfft;

    localparam int SB   = 3;
    localparam int DW   = 16;
    localparam int NFFT = 1 << SB;

    typedef struct {
        logic [DW-1:0] ei;
        logic [DW-1:0] eq;
        logic [DW-1:0] oi;
        logic [DW-1:0] oq;
        int            k;
    } pair_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data_i = '0;
    logic [DW-1:0] in_data_q = '0;
    logic          in_valid = 1'b0;
    logic          in_start = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_chet_i;
    logic [DW-1:0] out_chet_q;
    logic [DW-1:0] out_Nchet_i;
    logic [DW-1:0] out_Nchet_q;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SB-2:0] out_index;
    logic          out_first;
    logic          out_last;
    logic          err_sync;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: position in frame,
    // held even sample, pairs not yet consumed
    int            m_n = 0;
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_hq;
    logic          m_err = 1'b0;
    pair_t         m_q[$];

    split_mfft_to_two_sfft #(
        .SIZE_BUFFER  (SB),
        .DATA_FFT_SIZE(DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data_i  (in_data_i),
        .in_data_q  (in_data_q),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .in_ready   (in_ready),
        .out_chet_i (out_chet_i),
        .out_chet_q (out_chet_q),
        .out_Nchet_i(out_Nchet_i),
        .out_Nchet_q(out_Nchet_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_first  (out_first),
        .out_last   (out_last),
        .err_sync   (err_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic s,
                                input logic [DW-1:0] di,
                                input logic [DW-1:0] dq);
        pair_t p;
        if (s && m_n != 0) begin
            m_err = 1'b1;
            m_hi  = di;
            m_hq  = dq;
            m_n   = 1;
        end else begin
            if (m_n % 2 == 0) begin
                m_hi = di;
                m_hq = dq;
            end else begin
                p.ei = m_hi;
                p.eq = m_hq;
                p.oi = di;
                p.oq = dq;
                p.k  = m_n / 2;
                m_q.push_back(p);
            end
            m_n = (m_n + 1) % NFFT;
        end
    endtask

    task automatic step(input logic v,
                        input logic s,
                        input logic [DW-1:0] di,
                        input logic [DW-1:0] dq,
                        input logic ordy,
                        output logic acc);
        pair_t p;
        logic  exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_start  = s;
        in_data_i = di;
        in_data_q = dq;
        out_ready = ordy;
        #1;
        exp_rdy = !((m_n % 2 == 1) && m_q.size() == 2);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid),
            64'(m_q.size() != 0));
        chk("err_sync", 64'(err_sync), 64'(m_err));
        if (m_q.size() != 0 && out_valid) begin
            p = m_q[0];
            chk("even_i", 64'(out_chet_i), 64'(p.ei));
            chk("even_q", 64'(out_chet_q), 64'(p.eq));
            chk("odd_i", 64'(out_Nchet_i), 64'(p.oi));
            chk("odd_q", 64'(out_Nchet_q), 64'(p.oq));
            chk("index", 64'(out_index), 64'(p.k));
            chk("first", 64'(out_first), 64'(p.k == 0));
            chk("last", 64'(out_last),
                64'(p.k == NFFT / 2 - 1));
            if (ordy)
                void'(m_q.pop_front());
        end
        acc = v && in_ready;
        if (acc)
            model_accept(s, di, dq);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_n   = 0;
        m_err = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_err_sync", 64'(err_sync), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_first", 64'(out_first), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'({out_chet_i, out_chet_q,
            out_Nchet_i, out_Nchet_q}), 64'd0);
    endtask

    task automatic drain();
        logic acc;
        for (int t = 0; t < 20 && m_q.size() != 0; t++)
            step(1'b0, 1'b0, '0, '0, 1'b1, acc);
        chk("drain_empty", 64'(m_q.size()), 64'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   tries;
        logic v;
        logic s;

        do_reset();

        // back-to-back streaming
        for (int i = 0; i < NFFT; i++)
            step(1'b1, i == 0, DW'(i), DW'(-i), 1'b1, acc);
        drain();

        // backpressure
        sent = 0;
        for (int t = 0; t < 20 && sent < NFFT; t++) begin
            step(1'b1, sent == 0, DW'(sent), DW'(-sent),
                 1'b0, acc);
            if (acc) sent++;
            else break;
        end
        chk("bp_accepted", 64'(sent), 64'd5);
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 1'b0, DW'(sent), DW'(-sent),
                 1'b0, acc);
            if (acc) sent++;
        end
        for (int t = 0; t < 40 && sent < NFFT; t++) begin
            step(1'b1, 1'b0, DW'(sent), DW'(-sent),
                 1'b1, acc);
            if (acc) sent++;
        end
        chk("bp_sent", 64'(sent), 64'(NFFT));
        drain();

        // resync on an early in_start
        for (int i = 0; i < 3; i++)
            step(1'b1, i == 0, DW'(16'h0010 + i),
                 DW'(16'h0020 + i), 1'b1, acc);
        step(1'b1, 1'b1, 16'h0100, 16'h0200, 1'b1, acc);
        for (int i = 1; i < NFFT; i++)
            step(1'b1, 1'b0, DW'(16'h0100 + i),
                 DW'(16'h0200 + i), 1'b1, acc);
        chk("resync_err", 64'(err_sync), 64'd1);
        drain();

        // reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, i == 0, DW'(16'h0300 + i),
                 DW'(16'h0400 + i), 1'b0, acc);
        do_reset();
        for (int i = 0; i < NFFT; i++)
            step(1'b1, i == 0, DW'(16'h0500 + i),
                 DW'(16'h0600 + i), 1'b1, acc);
        drain();

        // random valid/ready gaps
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < NFFT; i++) begin
                logic [DW-1:0] ri;
                logic [DW-1:0] rq;
                ri = DW'($urandom);
                rq = DW'($urandom);
                tries = 0;
                acc = 1'b0;
                while (!acc && tries < 200) begin
                    v = ($urandom_range(0, 3) != 0);
                    s = v ? (i == 0)
                          : 1'($urandom_range(0, 1));
                    step(v, s, ri, rq,
                         1'($urandom_range(0, 1)), acc);
                    tries++;
                end
                if (!acc)
                    chk("rand_timeout", 64'd1, 64'd0);
            end
        end
        drain();
        chk("rand_err_sync", 64'(err_sync), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
